// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcodes, default width, stage state encoding.
// Latency: n/a (definitions only).  Backpressure: n/a.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_XOR = 3'b010;
    localparam logic [2:0] ALU_OP_ADD = 3'b011;
    localparam logic [2:0] ALU_OP_SUB = 3'b100;

    // 2'd3 is unreachable; the stage treats it as EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/alu_result_entry.sv
// One result slot {op, result, cout, zero, neg}; flags derived from the loaded result unless forwarded.
// Latency: load visible 1 cycle after ld.  Backpressure: none, holds until next ld or clear.
module alu_result_entry
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic              ld_keep_flags,
    input  logic [2:0]        ld_op,
    input  logic [DATA_W-1:0] ld_result,
    input  logic              ld_cout,
    input  logic              ld_zero,
    input  logic              ld_neg,
    output logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              zero,
    output logic              neg
);

    logic zero_d;
    logic neg_d;

    // Forwarded entries already carry valid flags, so skip recomputation on that path.
    always_comb begin
        zero_d = ld_keep_flags ? ld_zero : (ld_result == '0);
        neg_d  = ld_keep_flags ? ld_neg  : ld_result[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op     <= '0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else if (ld) begin
            op     <= ld_op;
            result <= ld_result;
            cout   <= ld_cout;
            zero   <= zero_d;
            neg    <= neg_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer (head + skid) with flags and a delivered-result counter.
// Latency: 1 cycle from push to out_valid when empty; 1 result/cycle sustained.
// Backpressure: absorbs one stalled beat in skid; in_ready registered-only (no path from out_ready).
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_op,
    output logic [DATA_W-1:0] out_result,
    output logic              out_cout,
    output logic              out_zero,
    output logic              out_neg,
    output logic [CNT_W-1:0]  out_count
);

    stage_state_t state, state_nxt;
    logic push, pop;
    logic head_ld, skid_ld, head_from_skid;

    logic [2:0]        skid_op;
    logic [DATA_W-1:0] skid_result;
    logic              skid_cout, skid_zero, skid_neg;

    logic [2:0]        head_op_d;
    logic [DATA_W-1:0] head_result_d;
    logic              head_cout_d;

    assign in_ready  = rst_n && (state != ST_FULL);
    assign out_valid = (state == ST_ONE) || (state == ST_FULL);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;
        case (state)
            ST_ONE: begin
                if (push && !pop) begin
                    skid_ld   = 1'b1;
                    state_nxt = ST_FULL;
                end else if (push && pop) begin
                    head_ld = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_ld        = 1'b1;
                    head_from_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                if (push) begin
                    head_ld   = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
        endcase
    end

    always_comb begin
        head_op_d     = head_from_skid ? skid_op     : in_op;
        head_result_d = head_from_skid ? skid_result : in_result;
        head_cout_d   = head_from_skid ? skid_cout   : in_cout;
    end

    alu_result_entry #(.DATA_W(DATA_W)) u_head (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld            (head_ld),
        .ld_keep_flags (head_from_skid),
        .ld_op         (head_op_d),
        .ld_result     (head_result_d),
        .ld_cout       (head_cout_d),
        .ld_zero       (skid_zero),
        .ld_neg        (skid_neg),
        .op            (out_op),
        .result        (out_result),
        .cout          (out_cout),
        .zero          (out_zero),
        .neg           (out_neg)
    );

    alu_result_entry #(.DATA_W(DATA_W)) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld            (skid_ld),
        .ld_keep_flags (1'b0),
        .ld_op         (in_op),
        .ld_result     (in_result),
        .ld_cout       (in_cout),
        .ld_zero       (1'b0),
        .ld_neg        (1'b0),
        .op            (skid_op),
        .result        (skid_result),
        .cout          (skid_cout),
        .zero          (skid_zero),
        .neg           (skid_neg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (pop) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed table plus hand-written sequences for the ALU result stage skid buffer.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_result;
    logic        in_cout;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_result;
    logic        out_cout;
    logic        out_zero;
    logic        out_neg;
    logic [15:0] out_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_count  (out_count)
    );

    typedef struct {
        logic        iv;
        logic [2:0]  op;
        logic [31:0] res;
        logic        cout;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [2:0]  e_op;
        logic [31:0] e_res;
        logic        e_cout;
        logic        e_zero;
        logic        e_neg;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] r, input logic c);
        in_valid  = v;
        in_op     = op;
        in_result = v ? r : 32'bx;
        in_cout   = c;
    endtask

    task automatic run_stream(input int n, input bit rnd, input logic [15:0] cnt0);
        logic [35:0] q[$];
        logic [35:0] e;
        logic [31:0] r;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int bubbles = 0;
        bit started = 1'b0;
        while (got < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            r = (sent % 10 == 5) ? 32'h0 : 32'(sent) * 32'h9E3779B1;
            drive((sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1),
                  3'(sent % 8), r, 1'(sent & 1));
            #1;
            if (!rnd && started && !out_valid) bubbles++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_spurious_pop", 64'(got), 64'(n + 1));
                end else begin
                    e = q.pop_front();
                    chk($sformatf("stream_pop%0d", got),
                        {27'd0, out_op, out_cout, out_zero, out_neg, out_result},
                        {27'd0, e[35:33], e[32], e[31:0] == 32'h0, e[31], e[31:0]});
                end
                got++;
                started = 1'b1;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_op, in_cout, in_result});
                sent++;
            end
        end
        @(negedge clk);
        drive(1'b0, 3'd0, 32'd0, 1'b0);
        out_ready = 1'b0;
        chk("stream_timeout", 64'(cyc < 5000), 64'd1);
        chk("stream_leftover", 64'(q.size()), 64'd0);
        chk("stream_count", 64'(out_count), 64'(16'(cnt0 + 16'(n))));
        chk("stream_drained", 64'(out_valid), 64'd0);
        if (!rnd) chk("stream_bubbles", 64'(bubbles), 64'd0);
    endtask

    initial begin
        //            iv    op     res            cout  ordy  irdy  ov    e_op   e_res          e_cout e_zero e_neg e_cnt
        vt[0] = '{1'b1, 3'd2, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h00000000, 1'b0, 1'b1, 1'b0, 16'd0};
        vt[1] = '{1'b1, 3'd1, 32'h80000001, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 32'h00000000, 1'b0, 1'b1, 1'b0, 16'd0};
        vt[2] = '{1'b1, 3'd7, 32'h0000DEAD, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h00000000, 1'b0, 1'b1, 1'b0, 16'd0};
        vt[3] = '{1'b0, 3'd0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 32'h80000001, 1'b1, 1'b0, 1'b1, 16'd1};
        vt[4] = '{1'b1, 3'd3, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 16'd2};
        vt[5] = '{1'b0, 3'd0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd3};
        vt[6] = '{1'b0, 3'd0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd3};
        vt[7] = '{1'b1, 3'd4, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 16'd3};
        vt[8] = '{1'b1, 3'd2, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 16'd3};
        vt[9] = '{1'b0, 3'd0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 32'h00000100, 1'b0, 1'b0, 1'b0, 16'd4};

        // Reset held with traffic offered
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 32'hA5A5A5A5, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", 64'(in_ready), 64'd1);

        // Single XOR of zero
        drive(1'b1, 3'b010, 32'h0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("xor_valid", 64'(out_valid), 64'd1);
        chk("xor_flags", {61'd0, out_op == 3'b010, out_zero, out_neg}, 64'b110);
        drive(1'b0, 3'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk("xor_count", 64'(out_count), 64'd1);
        chk("xor_empty", 64'(out_valid), 64'd0);

        // Stall into skid, then drain in order
        do_reset(1);
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 32'h80000001, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd2, 32'h12345678, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 1'b0);
        chk("skid_in_ready", 64'(in_ready), 64'd0);
        chk("skid_head", {31'd0, out_zero, out_neg, out_result}, {31'd0, 1'b0, 1'b1, 32'h80000001});
        out_ready = 1'b1;
        @(negedge clk);
        chk("skid_second", {31'd0, out_valid, out_cout, out_result}, {31'd0, 1'b1, 1'b1, 32'h12345678});
        chk("skid_second_flags", {62'd0, out_zero, out_neg}, 64'd0);
        @(negedge clk);
        chk("skid_count", 64'(out_count), 64'd2);
        chk("skid_empty", 64'(out_valid), 64'd0);

        // Directed table
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].iv, vt[i].op, vt[i].res, vt[i].cout);
            out_ready = vt[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_hs", i), {62'd0, in_ready, out_valid}, {62'd0, vt[i].e_irdy, vt[i].e_ov});
            chk($sformatf("vec%0d_count", i), 64'(out_count), 64'(vt[i].e_cnt));
            if (vt[i].e_ov)
                chk($sformatf("vec%0d_data", i),
                    {26'd0, out_op, out_cout, out_zero, out_neg, out_result},
                    {26'd0, vt[i].e_op, vt[i].e_cout, vt[i].e_zero, vt[i].e_neg, vt[i].e_res});
        end

        // Streaming, then random handshakes
        do_reset(1);
        run_stream(100, 1'b0, 16'd0);
        run_stream(100, 1'b1, 16'd100);

        // Reset while FULL with a nonzero count
        do_reset(1);
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h11111111, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 32'h22222222, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h33333333, 1'b0);
        @(negedge clk);
        chk("mid_full", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, 1'b1});
        chk("mid_count_pre", 64'(out_count), 64'd1);
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 1'b0);
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("mid_rst_state", {30'd0, out_valid, out_count, out_result}, 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_entries_gone", {47'd0, out_valid, out_count}, 64'd0);

        // Counter wrap
        do_reset(1);
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 32'h1, 1'b0);
        repeat (65536) @(negedge clk);
        chk("wrap_ffff", 64'(out_count), 64'hFFFF);
        @(negedge clk);
        chk("wrap_zero", 64'(out_count), 64'h0);
        drive(1'b0, 3'd0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
